// File: rtl/sr_latch_bank_arbiter.sv
// Two-requester arbiter that sequences safe S/R/enable writes into a
// bank of gated SR NOR latches and verifies the stored value.
module sr_latch_bank_arbiter #(
  parameter int N_LATCH    = 4,
  parameter int IDX_W      = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ_A,
  input  logic [IDX_W-1:0]   IDX_A,
  input  logic               VAL_A,
  input  logic               REQ_B,
  input  logic [IDX_W-1:0]   IDX_B,
  input  logic               VAL_B,
  output logic               ACK_A,
  output logic               ACK_B,
  output logic               ERR,
  output logic               BUSY,
  output logic [N_LATCH-1:0] S_OUT,
  output logic [N_LATCH-1:0] R_OUT,
  output logic [N_LATCH-1:0] EN_OUT,
  input  logic [N_LATCH-1:0] Q_IN
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] STROBE = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] VERIFY = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               val_q, val_d;
  logic               sel_b_q, sel_b_d;
  logic               last_b_q, last_b_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_LATCH-1:0] s_q, s_d;
  logic [N_LATCH-1:0] r_q, r_d;
  logic [N_LATCH-1:0] en_q, en_d;
  logic               ack_a_q, ack_a_d;
  logic               ack_b_q, ack_b_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic               gnt_b;
  logic [IDX_W-1:0]   nidx;
  logic               nval;
  logic               bad;
  logic [N_LATCH-1:0] nsel;
  logic [N_LATCH-1:0] csel;
  logic               mismatch;

  function automatic logic [N_LATCH-1:0] dec(input logic [IDX_W-1:0] i);
    logic [N_LATCH-1:0] o;
    o = '0;
    for (int k = 0; k < N_LATCH; k++) begin
      if (IDX_W'(k) == i) o[k] = 1'b1;
    end
    return o;
  endfunction

  // With both requests pending, the side not served last wins.
  assign gnt_b    = REQ_B & (~REQ_A | ~last_b_q);
  assign nidx     = gnt_b ? IDX_B : IDX_A;
  assign nval     = gnt_b ? VAL_B : VAL_A;
  assign bad      = {{(32-IDX_W){1'b0}}, nidx} >= 32'(N_LATCH);
  assign nsel     = dec(nidx);
  assign csel     = dec(idx_q);
  assign mismatch = (|(Q_IN & csel)) != val_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    val_d    = val_q;
    sel_b_d  = sel_b_q;
    last_b_d = last_b_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    r_d      = r_q;
    en_d     = '0;
    ack_a_d  = 1'b0;
    ack_b_d  = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (REQ_A | REQ_B) begin
          idx_d   = nidx;
          val_d   = nval;
          sel_b_d = gnt_b;
          if (bad) begin
            state_d = DONE;
            ack_a_d = ~gnt_b;
            ack_b_d = gnt_b;
            err_d   = 1'b1;
          end else begin
            state_d = SETUP;
            s_d     = nval ? nsel : '0;
            r_d     = nval ? '0 : nsel;
          end
        end
      end
      SETUP: begin
        state_d = STROBE;
        en_d    = csel;
      end
      STROBE: state_d = HOLD;
      HOLD: begin
        state_d = VERIFY;
        s_d     = '0;
        r_d     = '0;
        cnt_d   = '0;
      end
      VERIFY: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          ack_a_d = ~sel_b_q;
          ack_b_d = sel_b_q;
          err_d   = mismatch;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d  = IDLE;
        last_b_d = sel_b_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      val_q    <= 1'b0;
      sel_b_q  <= 1'b0;
      last_b_q <= 1'b1;
      cnt_q    <= '0;
      s_q      <= '0;
      r_q      <= '0;
      en_q     <= '0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      val_q    <= val_d;
      sel_b_q  <= sel_b_d;
      last_b_q <= last_b_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      r_q      <= r_d;
      en_q     <= en_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign S_OUT  = s_q;
  assign R_OUT  = r_q;
  assign EN_OUT = en_q;
  assign ACK_A  = ack_a_q;
  assign ACK_B  = ack_b_q;
  assign ERR    = err_q;
  assign BUSY   = busy_q;

endmodule
